// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: push/pop valid-ready handshake bundle for the SRAM FIFO controller
interface sram_fifo_ctrl_if #(
  parameter int DW = 18
);
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  modport master (output wr_valid, wr_data, rd_ready, input wr_ready, rd_valid, rd_data);
  modport slave  (input wr_valid, wr_data, rd_ready, output wr_ready, rd_valid, rd_data);
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FWFT FIFO around a 1024x18 dual-port SRAM with a 2-entry skid buffer; PARITY_EN enables stored parity
module sram_fifo_ctrl #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int DW        = 18,
  parameter int AFULL_THR = 1016
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_fifo_ctrl_if.slave s,
  output logic [AW+1:0] level,
  output logic          almost_full,
  output logic          par_err,
  output logic          sram_cen_a,
  output logic          sram_wen_a,
  output logic [AW-1:0] sram_addr_a,
  output logic [DW-1:0] sram_wmsk_a,
  output logic [DW-1:0] sram_wdata_a,
  output logic          sram_cen_b,
  output logic          sram_wen_b,
  output logic [AW-1:0] sram_addr_b,
  output logic [DW-1:0] sram_wmsk_b,
  output logic [DW-1:0] sram_wdata_b,
  input  logic [DW-1:0] sram_rdata_b
);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   mem_cnt_q, mem_cnt_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d, fill;
  logic [DW-1:0] buf0_q, buf0_d, buf1_q, buf1_d, wdata;
  logic [AW+1:0] level_q, level_d;
  logic          afull_q, afull_d, par_err_q, par_err_d;
  logic          full, push, pop, issue, bad;
  logic [2:0]    occ;
  // Handshakes, read-issue decision (a pop frees a slot this cycle), skid-buffer shifting and occupancy
  always_comb begin
    full       = mem_cnt_q == (AW+1)'(DEPTH);
    push       = s.wr_valid && rst_n && !full;
    pop        = buf_cnt_q != 2'd0 && s.rd_ready;
    occ        = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue      = mem_cnt_q != '0 && occ < 3'd2;
`ifdef PARITY_EN
    wdata      = {^s.wr_data[DW-3:8], ^s.wr_data[7:0], s.wr_data[DW-3:0]};
    bad        = inflight_q && (sram_rdata_b[DW-1] != ^sram_rdata_b[DW-3:8] ||
                                sram_rdata_b[DW-2] != ^sram_rdata_b[7:0]);
`else
    wdata      = s.wr_data;
    bad        = 1'b0;
`endif
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = issue ? rptr_q + AW'(1) : rptr_q;
    mem_cnt_d  = mem_cnt_q + (AW+1)'(push) - (AW+1)'(issue);
    inflight_d = issue;
    fill       = buf_cnt_q - 2'(pop);
    buf0_d     = inflight_q && fill == 2'd0 ? sram_rdata_b : pop ? buf1_q : buf0_q;
    buf1_d     = inflight_q && fill == 2'd1 ? sram_rdata_b : buf1_q;
    buf_cnt_d  = fill + 2'(inflight_q);
    level_d    = (AW+2)'(mem_cnt_d) + (AW+2)'(inflight_d) + (AW+2)'(buf_cnt_d);
    afull_d    = level_d >= (AW+2)'(AFULL_THR);
    par_err_d  = par_err_q || bad;
  end
  // State registers; SRAM contents are left alone by reset and simply become unreachable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= '0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      level_q    <= '0;
      afull_q    <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      level_q    <= level_d;
      afull_q    <= afull_d;
      par_err_q  <= par_err_d;
    end
  end
  assign s.wr_ready    = rst_n && !full;
  assign s.rd_valid    = buf_cnt_q != 2'd0;
  assign s.rd_data     = buf0_q;
  assign level         = level_q;
  assign almost_full   = afull_q;
  assign par_err       = par_err_q;
  assign sram_cen_a    = 1'b1;
  assign sram_wen_a    = !push;
  assign sram_addr_a   = wptr_q;
  assign sram_wmsk_a   = '0;
  assign sram_wdata_a  = wdata;
  assign sram_cen_b    = !issue;
  assign sram_wen_b    = 1'b1;
  assign sram_addr_b   = rptr_q;
  assign sram_wmsk_b   = '1;
  assign sram_wdata_b  = '0;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: randomized bench for sram_fifo_ctrl against a queue model and a behavioural SRAM
module tb_sram_fifo_ctrl;
  localparam int DEPTH = 1024, AW = 10, DW = 18, AFULL_THR = 1016;
`ifdef PARITY_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  sram_fifo_ctrl_if #(.DW(DW)) bus();
  logic [AW+1:0] level;
  logic          almost_full, par_err;
  logic          sram_cen_a, sram_wen_a, sram_cen_b, sram_wen_b;
  logic [AW-1:0] sram_addr_a, sram_addr_b;
  logic [DW-1:0] sram_wmsk_a, sram_wdata_a, sram_wmsk_b, sram_wdata_b, sram_rdata_b;
  sram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .AFULL_THR(AFULL_THR)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave), .level(level), .almost_full(almost_full),
    .par_err(par_err), .sram_cen_a(sram_cen_a), .sram_wen_a(sram_wen_a),
    .sram_addr_a(sram_addr_a), .sram_wmsk_a(sram_wmsk_a), .sram_wdata_a(sram_wdata_a),
    .sram_cen_b(sram_cen_b), .sram_wen_b(sram_wen_b), .sram_addr_b(sram_addr_b),
    .sram_wmsk_b(sram_wmsk_b), .sram_wdata_b(sram_wdata_b), .sram_rdata_b(sram_rdata_b));
  // behavioural SRAM macro; a read at corr_addr can be made to return bit 3 flipped
  logic [DW-1:0] mem [DEPTH];
  logic          corr_en = 1'b0;
  logic [AW-1:0] corr_addr = '0;
  always @(posedge clk) begin
    if (!sram_wen_a) mem[sram_addr_a] <= (mem[sram_addr_a] & sram_wmsk_a) | (sram_wdata_a & ~sram_wmsk_a);
    if (!sram_cen_b) sram_rdata_b <= mem[sram_addr_b] ^ ((corr_en && sram_addr_b == corr_addr) ? DW'(8) : DW'(0));
  end
  // reference model: queue of every held word, plus count of words written but not yet read from the SRAM
  logic [DW-1:0] q[$];
  int            nchk = 0, nfail = 0, mcnt = 0, wcnt = 0, rcnt = 0, qpre;
  logic          o_wr_ready, o_wen_a, o_cen_b, o_rd_valid, exp_ready, pushed, popped;
  logic [AW-1:0] o_addr_a, o_addr_b, exp_addr_a, exp_addr_b;
  logic [DW-1:0] o_rd_data, o_wdata_a, front;
  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] d);
`ifdef PARITY_EN
    return {^d[DW-3:8], ^d[7:0], d[DW-3:0]};
`else
    return d;
`endif
  endfunction
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    bus.wr_valid = wv; bus.wr_data = wd; bus.rd_ready = rr;
    #1;
    o_wr_ready = bus.wr_ready; o_wen_a = sram_wen_a; o_addr_a = sram_addr_a; o_wdata_a = sram_wdata_a;
    o_cen_b = sram_cen_b; o_addr_b = sram_addr_b; o_rd_valid = bus.rd_valid; o_rd_data = bus.rd_data;
    exp_ready = mcnt != DEPTH; exp_addr_a = AW'(wcnt % DEPTH); exp_addr_b = AW'(rcnt % DEPTH);
    pushed = wv && exp_ready; popped = o_rd_valid && rr; qpre = q.size();
    front = qpre > 0 ? q[0] : '0;
    @(posedge clk); #1;
    if (popped && qpre > 0) q.delete(0);
    if (pushed) begin q.push_back(exp_word(wd)); mcnt++; wcnt++; end
    if (!o_cen_b) begin mcnt--; rcnt++; end
  endtask
  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 20 && q.size() > 0; i++) begin
      step(1'b0, '0, 1'b1);
      if (popped) begin if (o_rd_data !== front) begin nfail++; $display("FAIL drain_data got=%h exp=%h", o_rd_data, front); end nchk++; end
    end
    if (q.size() != 0) begin nfail++; $display("FAIL drain_timeout left=%0d exp=0", q.size()); end nchk++;
    if (level !== '0) begin nfail++; $display("FAIL drain_level got=%0d exp=0", level); end nchk++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (bus.rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end nchk++;
    if (level !== '0) begin nfail++; $display("FAIL reset_level got=%0d exp=0", level); end nchk++;
    if (almost_full !== 1'b0) begin nfail++; $display("FAIL reset_afull got=%b exp=0", almost_full); end nchk++;
    if (bus.wr_ready !== 1'b0) begin nfail++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end nchk++;
    if (sram_wen_a !== 1'b1 || sram_cen_b !== 1'b1 || sram_cen_a !== 1'b1 || sram_wen_b !== 1'b1) begin nfail++; $display("FAIL reset_strobes got=%b%b%b%b exp=1111", sram_cen_a, sram_wen_a, sram_cen_b, sram_wen_b); end nchk++;
    if (par_err !== 1'b0) begin nfail++; $display("FAIL reset_par_err got=%b exp=0", par_err); end nchk++;
    bus.wr_valid = 1'b0; rst_n = 1'b1;
    #1;
    if (bus.wr_ready !== 1'b1) begin nfail++; $display("FAIL reset_release_wr_ready got=%b exp=1", bus.wr_ready); end nchk++;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    if (level !== '0) begin nfail++; $display("FAIL single_level0 got=%0d exp=0", level); end nchk++;
    step(1'b1, 18'h2A5A5, 1'b0);
    if (o_wen_a !== 1'b0 || o_addr_a !== exp_addr_a) begin nfail++; $display("FAIL single_write got=wen%b/addr%0d exp=wen0/addr%0d", o_wen_a, o_addr_a, exp_addr_a); end nchk++;
    if (level !== 1 || bus.rd_valid !== 1'b0) begin nfail++; $display("FAIL single_e1 got=lvl%0d/v%b exp=lvl1/v0", level, bus.rd_valid); end nchk++;
    step(1'b0, '0, 1'b0);
    if (o_wen_a !== 1'b1 || o_cen_b !== 1'b0) begin nfail++; $display("FAIL single_issue got=wen%b/cenb%b exp=wen1/cenb0", o_wen_a, o_cen_b); end nchk++;
    if (level !== 1 || bus.rd_valid !== 1'b0) begin nfail++; $display("FAIL single_e2 got=lvl%0d/v%b exp=lvl1/v0", level, bus.rd_valid); end nchk++;
    step(1'b0, '0, 1'b0);
    if (o_wen_a !== 1'b1) begin nfail++; $display("FAIL single_wen_e3 got=%b exp=1", o_wen_a); end nchk++;
    if (level !== 1 || bus.rd_valid !== 1'b1 || bus.rd_data !== exp_word(18'h2A5A5)) begin nfail++; $display("FAIL single_e3 got=lvl%0d/v%b/%h exp=lvl1/v1/%h", level, bus.rd_valid, bus.rd_data, exp_word(18'h2A5A5)); end nchk++;
    step(1'b0, '0, 1'b1);
    if (level !== 0 || bus.rd_valid !== 1'b0) begin nfail++; $display("FAIL single_pop got=lvl%0d/v%b exp=lvl0/v0", level, bus.rd_valid); end nchk++;
  endtask
  task automatic test_stream();
    int npop = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, DW'(i), 1'b1);
      if (o_wr_ready !== 1'b1) begin nfail++; $display("FAIL stream_wr_ready cyc=%0d got=%b exp=1", i, o_wr_ready); end nchk++;
      if (i >= 3 && o_rd_valid !== 1'b1) begin nfail++; $display("FAIL stream_gap cyc=%0d got=%b exp=1", i, o_rd_valid); end nchk++;
      if (popped) begin npop++; if (o_rd_data !== front) begin nfail++; $display("FAIL stream_data got=%h exp=%h", o_rd_data, front); end nchk++; end
    end
    if (npop != 1997) begin nfail++; $display("FAIL stream_pops got=%0d exp=1997", npop); end nchk++;
    drain();
  endtask
  task automatic test_fill();
    for (int i = 0; i < 1040; i++) begin
      step(1'b1, DW'($urandom), 1'b0);
      if (o_wr_ready !== exp_ready) begin nfail++; $display("FAIL fill_wr_ready cyc=%0d got=%b exp=%b", i, o_wr_ready, exp_ready); end nchk++;
      if (level !== (AW+2)'(q.size())) begin nfail++; $display("FAIL fill_level got=%0d exp=%0d", level, q.size()); end nchk++;
      if (almost_full !== (q.size() >= AFULL_THR)) begin nfail++; $display("FAIL fill_afull lvl=%0d got=%b", q.size(), almost_full); end nchk++;
    end
    if (level !== 1026 || q.size() != 1026) begin nfail++; $display("FAIL fill_max got=%0d/%0d exp=1026", level, q.size()); end nchk++;
    step(1'b1, DW'($urandom), 1'b1);
    if (o_wr_ready !== 1'b0) begin nfail++; $display("FAIL fill_full_ready got=%b exp=0", o_wr_ready); end nchk++;
    if (o_rd_data !== front) begin nfail++; $display("FAIL fill_pop_data got=%h exp=%h", o_rd_data, front); end nchk++;
    step(1'b0, '0, 1'b0);
    if (bus.wr_ready !== 1'b1) begin nfail++; $display("FAIL fill_ready_after_pop got=%b exp=1", bus.wr_ready); end nchk++;
    if (level !== 1025) begin nfail++; $display("FAIL fill_level_after_pop got=%0d exp=1025", level); end nchk++;
    drain();
  endtask
  task automatic test_random();
    logic wv, rr;
    logic [DW-1:0] wd;
    for (int i = 0; i < 10000; i++) begin
      wv = 1'($urandom); rr = 1'($urandom); wd = DW'($urandom);
      step(wv, wd, rr);
      if (o_wr_ready !== exp_ready || o_wen_a !== !pushed) begin nfail++; $display("FAIL rand_push cyc=%0d got=rdy%b/wen%b exp=rdy%b/wen%b", i, o_wr_ready, o_wen_a, exp_ready, !pushed); end nchk++;
      if (pushed && (o_addr_a !== exp_addr_a || o_wdata_a !== exp_word(wd))) begin nfail++; $display("FAIL rand_wr_bus cyc=%0d got=%0d/%h exp=%0d/%h", i, o_addr_a, o_wdata_a, exp_addr_a, exp_word(wd)); end nchk++;
      if (!o_cen_b && (mcnt + 1 - int'(pushed) <= 0 || o_addr_b !== exp_addr_b)) begin nfail++; $display("FAIL rand_issue cyc=%0d got=addr%0d exp=addr%0d words=%0d", i, o_addr_b, exp_addr_b, mcnt + 1 - int'(pushed)); end nchk++;
      if (o_rd_valid && qpre == 0) begin nfail++; $display("FAIL rand_valid_empty cyc=%0d got=1 exp=0", i); end nchk++;
      if (popped && o_rd_data !== front) begin nfail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, o_rd_data, front); end nchk++;
      if (level !== (AW+2)'(q.size())) begin nfail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, q.size()); end nchk++;
      if (almost_full !== (q.size() >= AFULL_THR) || par_err !== 1'b0) begin nfail++; $display("FAIL rand_flags cyc=%0d got=af%b/pe%b lvl=%0d", i, almost_full, par_err, q.size()); end nchk++;
    end
    drain();
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 500; i++) step(1'b1, DW'($urandom), 1'b0);
    if (level !== 500) begin nfail++; $display("FAIL mid_prefill got=%0d exp=500", level); end nchk++;
    bus.wr_valid = 1'b1; rst_n = 1'b0;
    #1;
    if (bus.rd_valid !== 1'b0 || level !== '0) begin nfail++; $display("FAIL mid_reset_state got=v%b/lvl%0d exp=v0/lvl0", bus.rd_valid, level); end nchk++;
    if (sram_wen_a !== 1'b1 || sram_cen_b !== 1'b1 || bus.wr_ready !== 1'b0) begin nfail++; $display("FAIL mid_reset_strobes got=wen%b/cenb%b/rdy%b exp=1/1/0", sram_wen_a, sram_cen_b, bus.wr_ready); end nchk++;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; rst_n = 1'b1;
    q.delete(); mcnt = 0; wcnt = 0; rcnt = 0;
    step(1'b1, 18'h00001, 1'b0);
    for (int i = 0; i < 10 && !bus.rd_valid; i++) step(1'b0, '0, 1'b0);
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_word(18'h00001)) begin nfail++; $display("FAIL mid_first_word got=v%b/%h exp=v1/%h", bus.rd_valid, bus.rd_data, exp_word(18'h00001)); end nchk++;
    drain();
  endtask
  task automatic test_parity();
    logic [DW-1:0] d;
    d = 18'h13C6B;
    if (par_err !== 1'b0) begin nfail++; $display("FAIL par_clean got=%b exp=0", par_err); end nchk++;
    corr_en = 1'b1; corr_addr = AW'(wcnt % DEPTH);
    step(1'b1, d, 1'b0);
    step(1'b0, '0, 1'b0);
    if (par_err !== 1'b0) begin nfail++; $display("FAIL par_early got=%b exp=0", par_err); end nchk++;
    step(1'b0, '0, 1'b0);
    corr_en = 1'b0;
    if (par_err !== PAR_EXP) begin nfail++; $display("FAIL par_set got=%b exp=%b", par_err, PAR_EXP); end nchk++;
    if (bus.rd_data !== (exp_word(d) ^ DW'(8))) begin nfail++; $display("FAIL par_data got=%h exp=%h", bus.rd_data, exp_word(d) ^ DW'(8)); end nchk++;
    step(1'b0, '0, 1'b1);
    q.delete();
    for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b1);
    drain();
    if (par_err !== PAR_EXP) begin nfail++; $display("FAIL par_sticky got=%b exp=%b", par_err, PAR_EXP); end nchk++;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fill();
    test_random();
    test_reset_mid();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
